syscall_responder: RTL and testbench
====================================

SYSCALL_RESPONDER -- requirements
Module: syscall_responder

Interface
REQ-001 Parameter SCAN_DIV, default 16'd50000, clock cycles per display digit slot.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 show  input  1  decoded syscall "display $a0" request from the syscall decoder.
REQ-005 halt  input  1  decoded syscall "halt" request from the syscall decoder.
REQ-006 a0  input  32  current $a0 register value.
REQ-007 go  input  1  resume button, debounced, synchronous to clk, active-high level.
REQ-008 cpu_en  output  1  CPU commit/PC enable; 0 freezes the datapath.
REQ-009 disp_data  output  32  last displayed $a0 value.
REQ-010 syscall_cnt  output  16  count of committed show events plus halt entries.
REQ-011 an  output  8  digit anodes, active-low one-hot.
REQ-012 seg  output  8  cathodes, active-low; seg[7]=dp, seg[6:0]=gfedcba.

Function
REQ-013 FSM states SHALL be RUN, HALTED, STEP.
REQ-014 cpu_en SHALL be combinational: RUN -> ~halt; HALTED -> 0; STEP -> 1.
REQ-015 In RUN with halt=1, next state SHALL be HALTED.
REQ-016 In HALTED, a go rising edge (go=1, previous-cycle go=0) SHALL move to STEP; go held high SHALL NOT retrigger.
REQ-017 STEP SHALL last exactly one cycle and then go to RUN; halt SHALL be ignored in STEP.
REQ-018 show SHALL commit only when cpu_en=1 and halt=0; on commit, disp_data SHALL take a0 at the next edge (1-cycle latency).
REQ-019 When show and halt are both 1, halt SHALL take priority; show SHALL be discarded.
REQ-020 syscall_cnt SHALL increment by 1 on each committed show and each RUN->HALTED transition; saturate at 16'hFFFF.
REQ-021 A scan counter SHALL count 0..SCAN_DIV-1; at SCAN_DIV-1, it SHALL wrap to 0 and advance the 3-bit digit index.
REQ-022 Digit index 7 SHALL wrap to 0.
REQ-023 an SHALL be all ones except bit[idx]=0.
REQ-024 seg[6:0] SHALL encode nibble disp_data[4*idx+3:4*idx] as active-low hex 0-F. Required encodings: 0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110.
REQ-025 seg[7] SHALL be constant 1 (dp off).
REQ-026 an and seg SHALL be registered outputs, updated one cycle after the index changes.
REQ-027 Display scanning SHALL continue in every FSM state.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force state=RUN, disp_data=0, syscall_cnt=0, scan counter=0, idx=0, go history=0, an=8'hFE, seg=8'hC0.
REQ-029 Reset SHALL override every other event, including reset asserted while HALTED or during STEP.
REQ-030 While rst_n=0, cpu_en SHALL be 1 when halt=0.

Verification
REQ-031 Scenario 1: show=1, a0=32'h1234ABCD in RUN -> next cycle disp_data=32'h1234ABCD, syscall_cnt=1; cpu_en stays 1.
REQ-032 Scenario 2: halt=1 in RUN -> cpu_en=0 in that same cycle; state HALTED; syscall_cnt+1. go held at 1 for 10 cycles after one rising edge -> exactly one cycle of cpu_en=1 (STEP), then RUN.
REQ-033 Scenario 3: show=1 and halt=1 together -> disp_data unchanged, HALTED entered, syscall_cnt +1 only.
REQ-034 Scenario 4: SCAN_DIV=4, disp_data=32'h0123_89AF -> an cycles FE,FD,...,7F every 4 cycles, then back to FE; seg[6:0] for digit 0 = 0001110 (F), digit 1 = 0001000 (A).
REQ-035 Scenario 5: syscall_cnt preloaded to 16'hFFFE via repeated shows -> two more shows -> holds at 16'hFFFF.
REQ-036 Scenario 6: rst_n=0 for one edge while HALTED with disp_data nonzero -> state RUN, disp_data=0, an=8'hFE, seg=8'hC0.

Source files
------------

// File: rtl/syscall_responder.sv
// Syscall responder: freezes the CPU on a halt syscall, single-steps on a
// "go" rising edge, latches $a0 on a display syscall, counts syscall events,
// and scans the latched value onto an 8-digit multiplexed 7-segment display.
module syscall_responder #(
    parameter logic [15:0] SCAN_DIV = 16'd50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        show,
    input  logic        halt,
    input  logic [31:0] a0,
    input  logic        go,
    output logic        cpu_en,
    output logic [31:0] disp_data,
    output logic [15:0] syscall_cnt,
    output logic [7:0]  an,
    output logic [7:0]  seg
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        STEP   = 2'd2
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic        go_prev_r;
    logic        go_rise_s;
    logic        fsm_en_s;
    logic        commit_s;
    logic        halt_entry_s;
    logic        cnt_inc_s;
    logic [31:0] disp_data_r;
    logic [15:0] syscall_cnt_r;
    logic [15:0] scan_cnt_r;
    logic [2:0]  idx_r;
    logic [7:0]  an_r;
    logic [7:0]  seg_r;
    logic        scan_wrap_s;
    logic [3:0]  nibble_s;

    // Active-low hex decoder, bit order gfedcba.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            4'hF:    s = 7'b0001110;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Next-state logic and the state-derived CPU enable.
    always_comb begin
        next_state_s = state_r;
        fsm_en_s     = 1'b1;
        go_rise_s    = go & ~go_prev_r;
        case (state_r)
            RUN: begin
                fsm_en_s = ~halt;
                if (halt) begin
                    next_state_s = HALTED;
                end else begin
                    next_state_s = RUN;
                end
            end
            HALTED: begin
                fsm_en_s = 1'b0;
                if (go_rise_s) begin
                    next_state_s = STEP;
                end else begin
                    next_state_s = HALTED;
                end
            end
            STEP: begin
                // Halt is deliberately ignored so the step always completes.
                fsm_en_s     = 1'b1;
                next_state_s = RUN;
            end
            default: begin
                fsm_en_s     = ~halt;
                next_state_s = RUN;
            end
        endcase
    end

    // Commit and counting qualifiers; during reset the CPU behaves as in RUN.
    always_comb begin
        if (!rst_n) begin
            cpu_en = ~halt;
        end else begin
            cpu_en = fsm_en_s;
        end
        commit_s     = show & fsm_en_s & ~halt;
        halt_entry_s = (state_r == RUN) & halt;
        cnt_inc_s    = commit_s | halt_entry_s;
    end

    // FSM state and go-edge history.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= RUN;
            go_prev_r <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            go_prev_r <= go;
        end
    end

    // Displayed value and saturating syscall counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp_data_r   <= 32'h0000_0000;
            syscall_cnt_r <= 16'h0000;
        end else begin
            if (commit_s) begin
                disp_data_r <= a0;
            end else begin
                disp_data_r <= disp_data_r;
            end
            if (cnt_inc_s && (syscall_cnt_r != 16'hFFFF)) begin
                syscall_cnt_r <= syscall_cnt_r + 16'd1;
            end else begin
                syscall_cnt_r <= syscall_cnt_r;
            end
        end
    end

    // Wrap condition for the per-digit dwell counter and the active nibble.
    always_comb begin
        scan_wrap_s = (scan_cnt_r == (SCAN_DIV - 16'd1));
        nibble_s    = disp_data_r[{idx_r, 2'b00} +: 4];
    end

    // Digit scan timing; runs regardless of the CPU state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt_r <= 16'd0;
            idx_r      <= 3'd0;
        end else begin
            if (scan_wrap_s) begin
                scan_cnt_r <= 16'd0;
                idx_r      <= idx_r + 3'd1;
            end else begin
                scan_cnt_r <= scan_cnt_r + 16'd1;
                idx_r      <= idx_r;
            end
        end
    end

    // Registered anode/cathode drive, one cycle behind the digit index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an_r  <= 8'hFE;
            seg_r <= 8'hC0;
        end else begin
            an_r  <= ~(8'd1 << idx_r);
            seg_r <= {1'b1, hex_to_seg(nibble_s)};
        end
    end

    assign disp_data   = disp_data_r;
    assign syscall_cnt = syscall_cnt_r;
    assign an          = an_r;
    assign seg         = seg_r;

endmodule

// File: tb/tb_syscall_responder.sv
// Directed bench for syscall_responder with a scoreboard of expected values.
module tb_syscall_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        show;
    logic        halt;
    logic        go;
    logic [31:0] a0;
    logic        cpu_en;
    logic [31:0] disp_data;
    logic [15:0] syscall_cnt;
    logic [7:0]  an;
    logic [7:0]  seg;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic [31:0] exp_disp;
    logic [15:0] exp_cnt;
    logic [7:0]  exp_an;

    syscall_responder #(.SCAN_DIV(16'd4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .show        (show),
        .halt        (halt),
        .a0          (a0),
        .go          (go),
        .cpu_en      (cpu_en),
        .disp_data   (disp_data),
        .syscall_cnt (syscall_cnt),
        .an          (an),
        .seg         (seg)
    );

    always #5 clk = ~clk;

    // Expected seg byte for each digit of 32'h0123_89AF (dp off).
    function automatic logic [7:0] digit_seg(input int d);
        case (d)
            0:       return 8'h8E;
            1:       return 8'h88;
            2:       return 8'h90;
            3:       return 8'h80;
            4:       return 8'hB0;
            5:       return 8'hA4;
            6:       return 8'hF9;
            7:       return 8'hC0;
            default: return 8'hFF;
        endcase
    endfunction

    task automatic push(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %h expected a queued value", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", t, obs, e);
            end
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic h,
                         input logic g, input logic [31:0] a);
        @(negedge clk);
        rst_n = r;
        show  = s;
        halt  = h;
        go    = g;
        a0    = a;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        show  = 1'b0;
        halt  = 1'b0;
        go    = 1'b0;
        a0    = 32'h0;

        // Reset state
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        push("rst_cpu_en", 32'd1); check({31'd0, cpu_en});
        tick();
        push("rst_disp", 32'h0);          check(disp_data);
        push("rst_cnt", 32'h0);           check({16'd0, syscall_cnt});
        push("rst_an", 32'h0000_00FE);    check({24'd0, an});
        push("rst_seg", 32'h0000_00C0);   check({24'd0, seg});

        // Scenario 4: scan 32'h0123_89AF with SCAN_DIV=4, including index wrap
        for (int i = 1; i <= 40; i++) begin
            if (i == 1) begin
                drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0123_89AF);
            end else begin
                drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
            end
            tick();
            if (i >= 2) begin
                exp_an = ~(8'd1 << (((i - 1) / 4) % 8));
                push("scan_an", {24'd0, exp_an});
                check({24'd0, an});
                push("scan_seg", {24'd0, digit_seg(((i - 1) / 4) % 8)});
                check({24'd0, seg});
            end
        end
        exp_disp = 32'h0123_89AF;
        exp_cnt  = 16'd1;
        push("s4_disp", exp_disp);        check(disp_data);
        push("s4_cnt", {16'd0, exp_cnt}); check({16'd0, syscall_cnt});

        // Scenario 1: show in RUN
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h1234_ABCD);
        push("s1_cpu_en", 32'd1); check({31'd0, cpu_en});
        tick();
        exp_disp = 32'h1234_ABCD;
        exp_cnt  = 16'd2;
        push("s1_disp", exp_disp);        check(disp_data);
        push("s1_cnt", {16'd0, exp_cnt}); check({16'd0, syscall_cnt});
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        push("s1_cpu_en_after", 32'd1); check({31'd0, cpu_en});

        // Scenario 2: halt, then single step on one go edge
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        push("s2_halt_cpu_en", 32'd0); check({31'd0, cpu_en});
        tick();
        exp_cnt = 16'd3;
        push("s2_cnt", {16'd0, exp_cnt}); check({16'd0, syscall_cnt});
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
        push("s2_halted_cpu_en", 32'd0); check({31'd0, cpu_en});
        tick();
        push("s2_halted_show_disp", exp_disp); check(disp_data);
        push("s2_halted_show_cnt", {16'd0, exp_cnt}); check({16'd0, syscall_cnt});
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
        push("s2_go_edge_cpu_en", 32'd0); check({31'd0, cpu_en});
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
        push("s2_step_cpu_en", 32'd1); check({31'd0, cpu_en});
        tick();
        push("s2_step_cnt", {16'd0, exp_cnt}); check({16'd0, syscall_cnt});
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
        push("s2_rehalt_cpu_en", 32'd0); check({31'd0, cpu_en});
        tick();
        exp_cnt = 16'd4;
        push("s2_rehalt_cnt", {16'd0, exp_cnt}); check({16'd0, syscall_cnt});
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
            push("s2_go_held_cpu_en", 32'd0); check({31'd0, cpu_en});
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        push("s2_go_low_cpu_en", 32'd0); check({31'd0, cpu_en});
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        push("s2_go_edge2_cpu_en", 32'd0); check({31'd0, cpu_en});
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'hCAFE_F00D);
        push("s2_step_show_cpu_en", 32'd1); check({31'd0, cpu_en});
        tick();
        exp_disp = 32'hCAFE_F00D;
        exp_cnt  = 16'd5;
        push("s2_step_show_disp", exp_disp);        check(disp_data);
        push("s2_step_show_cnt", {16'd0, exp_cnt}); check({16'd0, syscall_cnt});
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        push("s2_run_cpu_en", 32'd1); check({31'd0, cpu_en});
        tick();

        // Scenario 3: show and halt together, halt wins
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'hFFFF_0000);
        push("s3_cpu_en", 32'd0); check({31'd0, cpu_en});
        tick();
        exp_cnt = 16'd6;
        push("s3_disp", exp_disp);        check(disp_data);
        push("s3_cnt", {16'd0, exp_cnt}); check({16'd0, syscall_cnt});
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        push("s3_halted_cpu_en", 32'd0); check({31'd0, cpu_en});

        // Scenario 6: reset while HALTED with nonzero display
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h1111_1111);
        push("s6_rst_cpu_en", 32'd1); check({31'd0, cpu_en});
        tick();
        push("s6_disp", 32'h0);        check(disp_data);
        push("s6_cnt", 32'h0);         check({16'd0, syscall_cnt});
        push("s6_an", 32'h0000_00FE);  check({24'd0, an});
        push("s6_seg", 32'h0000_00C0); check({24'd0, seg});
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        push("s6_run_cpu_en", 32'd1); check({31'd0, cpu_en});

        // Scenario 5: counter saturation
        for (int i = 0; i < 65534; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, i);
            tick();
        end
        exp_cnt  = 16'hFFFE;
        exp_disp = 32'd65533;
        push("s5_pre_cnt", {16'd0, exp_cnt}); check({16'd0, syscall_cnt});
        push("s5_pre_disp", exp_disp);        check(disp_data);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hA5A5_0000 + i);
            tick();
            push("s5_sat_cnt", 32'h0000_FFFF); check({16'd0, syscall_cnt});
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        push("s5_sat_halt_cnt", 32'h0000_FFFF); check({16'd0, syscall_cnt});
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
